sprite_line_sched: RTL and testbench

//  Per-scanline sprite scheduler in the PPU. Scans all 40 OAM entries on line_start
//  and keeps the first MAX_SPR sprites that cover line ly. It then drives an external

---
 rtl/sprite_sched_pkg.sv | 20 ++
 rtl/sprite_y_hit.sv | 19 +
 rtl/sprite_line_sched.sv | 183 ++++++++++++++++++
 tb/tb_sprite_line_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared encodings and sizes for the per-scanline sprite scheduler.
package sprite_sched_pkg;
    localparam int OAM_N       = 40;
    localparam int MAX_SPR     = 10;
    localparam int SORT_WAIT   = 10;
    localparam int Y_OFFSET    = 16;
    localparam int SPR_H_SHORT = 8;
    localparam int SPR_H_TALL  = 16;
    localparam int IDX_W       = 6;
    localparam int X_W         = 8;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SORT,
        ST_FETCH,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sprite_y_hit.sv
// Combinational test: does an OAM entry's Y range cover scanline ly?
module sprite_y_hit
    import sprite_sched_pkg::*;
(
    input  logic [X_W-1:0] ly,
    input  logic [X_W-1:0] oam_y,
    input  logic           tall,
    output logic           hit
);
    logic [8:0] line_pos;
    logic [8:0] spr_end;

    // 9-bit math so ly+16 and oam_y+height never wrap
    always_comb begin
        line_pos = {1'b0, ly} + 9'(Y_OFFSET);
        spr_end  = {1'b0, oam_y} + (tall ? 9'(SPR_H_TALL) : 9'(SPR_H_SHORT));
        hit      = (line_pos >= {1'b0, oam_y}) && (line_pos < spr_end);
    end
endmodule

// File: rtl/sprite_line_sched.sv
// Scanline sprite scheduler: OAM scan, external sort handshake, ordered fetch requests.
// Optional SPRITE_SCHED_CGB_ORDER_EN adds cgb_order (fetch in OAM order, no sort).
module sprite_line_sched #(
    parameter int OAM_N     = 40,
    parameter int MAX_SPR   = 10,
    parameter int SORT_WAIT = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 line_start,
    input  logic [7:0]           ly,
    input  logic                 tall,
    output logic [5:0]           oam_addr,
    input  logic [7:0]           oam_y,
    input  logic [7:0]           oam_x,
    output logic                 sort_load,
    output logic [8*MAX_SPR-1:0] sort_x,
    input  logic [6*MAX_SPR-1:0] sort_idx,
    output logic                 fetch_req,
    output logic [5:0]           fetch_oam_idx,
    output logic [7:0]           fetch_x,
    input  logic                 fetch_ack,
`ifdef SPRITE_SCHED_CGB_ORDER_EN
    input  logic                 cgb_order,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           spr_count
);
    import sprite_sched_pkg::*;

    localparam int WAIT_W = $clog2(SORT_WAIT + 1);

    state_t             state;
    logic [IDX_W-1:0]   slot_oam [MAX_SPR];
    logic [X_W-1:0]     slot_x   [MAX_SPR];
    logic               vld_p0;
    logic               vld_p1;
    logic [IDX_W-1:0]   idx_p1;
    logic               hit_p1;
    logic [X_W-1:0]     ly_q;
    logic               tall_q;
    logic               cgb_q;
    logic               cgb_in;
    logic [CNT_W-1:0]   rank;
    logic [CNT_W-1:0]   rank_nxt;
    logic [CNT_W-1:0]   slot_nxt;
    logic [IDX_W-1:0]   nxt_idx;
    logic [X_W-1:0]     nxt_x;
    logic [WAIT_W-1:0]  wait_cnt;

`ifdef SPRITE_SCHED_CGB_ORDER_EN
    assign cgb_in = cgb_order;
`else
    assign cgb_in = 1'b0;
`endif

    // Map a fetch rank to a slot: identity in OAM order, else the sorter's answer
    function automatic logic [CNT_W-1:0] rank_slot(input logic [CNT_W-1:0] r,
                                                   input logic in_order,
                                                   input logic [6*MAX_SPR-1:0] idx_vec);
        logic [IDX_W-1:0] s;
        if (int'(r) >= MAX_SPR) return '0;
        s = in_order ? IDX_W'(r) : idx_vec[int'(r)*IDX_W +: IDX_W];
        return (int'(s) < MAX_SPR) ? s[CNT_W-1:0] : '0;
    endfunction

    sprite_y_hit u_y_hit (
        .ly    (ly_q),
        .oam_y (oam_y),
        .tall  (tall_q),
        .hit   (hit_p1)
    );

    always_comb begin
        rank_nxt = (state == ST_FETCH) ? rank + 1'b1 : '0;
        slot_nxt = rank_slot(rank_nxt, cgb_q, sort_idx);
        nxt_idx  = slot_oam[slot_nxt];
        nxt_x    = slot_x[slot_nxt];
        for (int i = 0; i < MAX_SPR; i++) sort_x[i*X_W +: X_W] = slot_x[i];
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            oam_addr      <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            idx_p1        <= '0;
            ly_q          <= '0;
            tall_q        <= 1'b0;
            cgb_q         <= 1'b0;
            spr_count     <= '0;
            rank          <= '0;
            wait_cnt      <= '0;
            sort_load     <= 1'b0;
            fetch_req     <= 1'b0;
            fetch_oam_idx <= '0;
            fetch_x       <= '0;
            done          <= 1'b0;
            for (int i = 0; i < MAX_SPR; i++) begin
                slot_oam[i] <= '0;
                slot_x[i]   <= 8'hFF;
            end
        end else if (line_start) begin
            // New line, or abort of the current one: restart the scan from entry 0
            state     <= ST_SCAN;
            oam_addr  <= '0;
            vld_p0    <= 1'b1;
            vld_p1    <= 1'b0;
            ly_q      <= ly;
            tall_q    <= tall;
            cgb_q     <= cgb_in;
            spr_count <= '0;
            rank      <= '0;
            wait_cnt  <= '0;
            sort_load <= 1'b0;
            fetch_req <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < MAX_SPR; i++) begin
                slot_oam[i] <= '0;
                slot_x[i]   <= 8'hFF;
            end
        end else begin
            sort_load <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_SCAN: begin
                    // p0: address issued; p1: OAM data back, evaluate hit
                    vld_p1 <= vld_p0;
                    idx_p1 <= oam_addr;
                    if (vld_p0) begin
                        if (oam_addr == 6'(OAM_N - 1)) vld_p0   <= 1'b0;
                        else                           oam_addr <= oam_addr + 1'b1;
                    end
                    if (vld_p1 && hit_p1 && (spr_count < 4'(MAX_SPR))) begin
                        slot_oam[spr_count] <= idx_p1;
                        slot_x[spr_count]   <= oam_x;
                        spr_count           <= spr_count + 1'b1;
                    end
                    if (vld_p1 && (idx_p1 == 6'(OAM_N - 1))) begin
                        state     <= ST_SORT;
                        sort_load <= !cgb_q;
                        wait_cnt  <= '0;
                    end
                end
                ST_SORT: begin
                    if (cgb_q || (wait_cnt == WAIT_W'(SORT_WAIT))) begin
                        if (spr_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ST_FETCH;
                            rank          <= '0;
                            fetch_req     <= 1'b1;
                            fetch_oam_idx <= nxt_idx;
                            fetch_x       <= nxt_x;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (fetch_ack) begin
                        if (rank == spr_count - 1'b1) begin
                            state     <= ST_DONE;
                            fetch_req <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rank          <= rank_nxt;
                            fetch_oam_idx <= nxt_idx;
                            fetch_x       <= nxt_x;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched with OAM memory, stable sorter model and fetch scoreboard.
module tb_sprite_line_sched;
    localparam int OAM_N     = 40;
    localparam int MAX_SPR   = 10;
    localparam int SORT_WAIT = 10;

    typedef struct {
        logic [5:0] idx;
        logic [7:0] x;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 line_start;
    logic [7:0]           ly;
    logic                 tall;
    logic [5:0]           oam_addr;
    logic [7:0]           oam_y;
    logic [7:0]           oam_x;
    logic                 sort_load;
    logic [8*MAX_SPR-1:0] sort_x;
    logic [6*MAX_SPR-1:0] sort_idx;
    logic                 fetch_req;
    logic [5:0]           fetch_oam_idx;
    logic [7:0]           fetch_x;
    logic                 fetch_ack;
    logic                 busy;
    logic                 done;
    logic [3:0]           spr_count;
`ifdef SPRITE_SCHED_CGB_ORDER_EN
    logic                 cgb_order;
`endif

    logic [7:0] mem_y [OAM_N];
    logic [7:0] mem_x [OAM_N];
    exp_t       exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         load_cnt = 0;

    always #5 clk = ~clk;

    sprite_line_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .line_start    (line_start),
        .ly            (ly),
        .tall          (tall),
        .oam_addr      (oam_addr),
        .oam_y         (oam_y),
        .oam_x         (oam_x),
        .sort_load     (sort_load),
        .sort_x        (sort_x),
        .sort_idx      (sort_idx),
        .fetch_req     (fetch_req),
        .fetch_oam_idx (fetch_oam_idx),
        .fetch_x       (fetch_x),
        .fetch_ack     (fetch_ack),
`ifdef SPRITE_SCHED_CGB_ORDER_EN
        .cgb_order     (cgb_order),
`endif
        .busy          (busy),
        .done          (done),
        .spr_count     (spr_count)
    );

    // OAM returns the addressed entry one cycle later
    always @(posedge clk) begin
        oam_y <= (int'(oam_addr) < OAM_N) ? mem_y[oam_addr] : 8'h00;
        oam_x <= (int'(oam_addr) < OAM_N) ? mem_x[oam_addr] : 8'h00;
    end

    // Stable ascending-X sorter (strict >)
    always @(posedge clk) begin : sorter_model
        int ord [MAX_SPR];
        int t;
        if (sort_load) begin
            for (int i = 0; i < MAX_SPR; i++) ord[i] = i;
            for (int i = 1; i < MAX_SPR; i++)
                for (int j = i; j > 0; j--)
                    if (sort_x[ord[j-1]*8 +: 8] > sort_x[ord[j]*8 +: 8]) begin
                        t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
                    end
            for (int i = 0; i < MAX_SPR; i++) sort_idx[i*6 +: 6] <= 6'(ord[i]);
        end
    end

    always @(negedge clk) begin
        if (done)      done_cnt++;
        if (sort_load) load_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_oam();
        for (int e = 0; e < OAM_N; e++) begin
            mem_y[e] = 8'd0;
            mem_x[e] = 8'd0;
        end
    endtask

    task automatic build_expect(input logic [7:0] ly_i, input logic tall_i,
                                input bit in_order, output int cnt);
        int sel [$];
        int d, h, t;
        exp_t e;
        exp_q.delete();
        cnt = 0;
        h = tall_i ? 16 : 8;
        for (int k = 0; k < OAM_N; k++) begin
            d = int'(ly_i) + 16 - int'(mem_y[k]);
            if (d >= 0 && d < h && cnt < MAX_SPR) begin
                sel.push_back(k);
                cnt++;
            end
        end
        if (!in_order)
            for (int i = 1; i < cnt; i++)
                for (int j = i; j > 0; j--)
                    if (mem_x[sel[j-1]] > mem_x[sel[j]]) begin
                        t = sel[j]; sel[j] = sel[j-1]; sel[j-1] = t;
                    end
        for (int i = 0; i < cnt; i++) begin
            e.idx = 6'(sel[i]);
            e.x   = mem_x[sel[i]];
            exp_q.push_back(e);
        end
    endtask

    task automatic start_line();
        @(negedge clk);
        line_start = 1'b1;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    // Serve fetches against the scoreboard until done; done_at = cycles after line_start edge
    task automatic service_line(input string tag, output int done_at);
        exp_t e;
        done_at = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            fetch_ack = 1'b0;
            if (done) begin
                done_at = n;
                break;
            end
            if (fetch_req) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_fetch"}, int'(fetch_oam_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_fetch_idx"}, int'(fetch_oam_idx), int'(e.idx));
                    check({tag, "_fetch_x"}, int'(fetch_x), int'(e.x));
                end
                fetch_ack = 1'b1;
            end
        end
        check({tag, "_done_seen"}, int'(done_at >= 0), 1);
        check({tag, "_missing_fetches"}, exp_q.size(), 0);
        @(negedge clk);
        fetch_ack = 1'b0;
        check({tag, "_done_width"}, int'(done), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int cnt, done_at, d0, l0;
        reset_n    = 1'b0;
        line_start = 1'b0;
        ly         = 8'd0;
        tall       = 1'b0;
        fetch_ack  = 1'b0;
`ifdef SPRITE_SCHED_CGB_ORDER_EN
        cgb_order  = 1'b0;
`endif
        clear_oam();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_req", int'(fetch_req), 0);
        check("rst_count", int'(spr_count), 0);
        check("rst_load", int'(sort_load), 0);
        check("rst_addr", int'(oam_addr), 0);
        check("rst_sort_x", int'(sort_x == {MAX_SPR{8'hFF}}), 1);
        reset_n = 1'b1;

        // Two hits, fetched in X order
        clear_oam();
        mem_y[3] = 8'd16; mem_x[3] = 8'd40;
        mem_y[7] = 8'd10; mem_x[7] = 8'd20;
        ly = 8'd0; tall = 1'b0;
        build_expect(ly, tall, 1'b0, cnt);
        l0 = load_cnt;
        start_line();
        service_line("t1", done_at);
        check("t1_count", int'(spr_count), cnt);
        check("t1_count_abs", int'(spr_count), 2);
        check("t1_loads", load_cnt - l0, 1);
        check("t1_slot0_x", int'(sort_x[7:0]), 40);
        check("t1_slot1_x", int'(sort_x[15:8]), 20);
        check("t1_slot2_x", int'(sort_x[23:16]), 255);

        // Twelve hits: saturate at MAX_SPR, only the first ten kept
        clear_oam();
        for (int k = 0; k < 12; k++) begin
            mem_y[k] = 8'd16;
            mem_x[k] = 8'(200 - 10 * k);
        end
        build_expect(ly, tall, 1'b0, cnt);
        start_line();
        service_line("t2", done_at);
        check("t2_count", int'(spr_count), 10);

        // Equal X keeps lower OAM index first
        clear_oam();
        mem_y[2] = 8'd16; mem_x[2] = 8'd50;
        mem_y[5] = 8'd16; mem_x[5] = 8'd50;
        build_expect(ly, tall, 1'b0, cnt);
        start_line();
        service_line("t3", done_at);
        check("t3_count", int'(spr_count), 2);

        // Tall sprite covers the line; short one does not
        clear_oam();
        mem_y[0] = 8'd16; mem_x[0] = 8'd33;
        ly = 8'd8; tall = 1'b1;
        build_expect(ly, tall, 1'b0, cnt);
        start_line();
        service_line("t4a", done_at);
        check("t4a_count", int'(spr_count), 1);
        tall = 1'b0;
        build_expect(ly, tall, 1'b0, cnt);
        start_line();
        service_line("t4b", done_at);
        check("t4b_count", int'(spr_count), 0);
        check("t4b_done_latency", done_at, OAM_N + 2 + SORT_WAIT);

        // Back-pressure, then abort during FETCH
        clear_oam();
        mem_y[3] = 8'd16; mem_x[3] = 8'd40;
        mem_y[7] = 8'd10; mem_x[7] = 8'd20;
        ly = 8'd0; tall = 1'b0;
        build_expect(ly, tall, 1'b0, cnt);
        d0 = done_cnt;
        start_line();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fetch_req) break;
        end
        check("t5_req_seen", int'(fetch_req), 1);
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_req", int'(fetch_req), 1);
            check("t5_hold_idx", int'(fetch_oam_idx), int'(exp_q[0].idx));
            check("t5_hold_x", int'(fetch_x), int'(exp_q[0].x));
        end
        start_line();
        check("t5_abort_req", int'(fetch_req), 0);
        check("t5_abort_busy", int'(busy), 1);
        check("t5_abort_count", int'(spr_count), 0);
        service_line("t5", done_at);
        check("t5_done_pulses", done_cnt - d0, 1);

`ifdef SPRITE_SCHED_CGB_ORDER_EN
        // OAM order: no sort, fetch walks slots
        clear_oam();
        mem_y[4] = 8'd16; mem_x[4] = 8'd90;
        mem_y[6] = 8'd16; mem_x[6] = 8'd10;
        cgb_order = 1'b1;
        build_expect(ly, tall, 1'b1, cnt);
        l0 = load_cnt;
        start_line();
        service_line("t6", done_at);
        check("t6_no_load", load_cnt - l0, 0);
        check("t6_count", int'(spr_count), 2);
        cgb_order = 1'b0;
`endif

        // Reset mid-scan clears state and slots
        clear_oam();
        mem_y[3] = 8'd16; mem_x[3] = 8'd40;
        start_line();
        repeat (10) @(negedge clk);
        check("mid_slot_filled", int'(sort_x[7:0]), 40);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_count", int'(spr_count), 0);
        check("mid_rst_sort_x", int'(sort_x == {MAX_SPR{8'hFF}}), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
